// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared opcode encodings, FSM state type and a width helper
//             for the multi-cycle multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  // Operation select encodings seen on the op input.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Sequencer states: wait for work, iterate, apply sign correction.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Ceiling log2, used to size the iteration counter at elaboration.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_udiv_nr_step.sv
`default_nettype none
// ============================================================================
//  Module   : udiv_nr_step
//  Purpose  : One combinational step of unsigned non-restoring division.
//             The partial remainder is shifted left taking in the next
//             dividend bit, then the divisor is added or subtracted
//             depending on the sign of the incoming partial remainder.
//  Revision : 1.0  initial release
// ============================================================================
module udiv_nr_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             shift_in,
  output logic [WIDTH+1:0] rem_out,
  output logic             q_bit
);

  // Two guard bits keep 2*P + bit representable while |P| < divisor.
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] dvsr_ext;

  // Shift, then add or subtract the divisor based on the remainder sign.
  always_comb begin
    rem_shift = {rem_in[WIDTH:0], shift_in};
    dvsr_ext  = {2'b00, divisor};
    if (rem_in[WIDTH+1]) begin
      rem_out = rem_shift + dvsr_ext;
    end else begin
      rem_out = rem_shift - dvsr_ext;
    end
    q_bit = ~rem_out[WIDTH+1];
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Multi-cycle signed multiply (radix-2 Booth) and divide
//             (non-restoring) engine feeding the Zhigh/Zlow bus sources.
//             Every operation takes WIDTH+1 cycles from the start edge
//             to the done pulse, including divide-by-zero.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] zhigh,
  output logic [WIDTH-1:0] zlow,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = clog2(WIDTH);
  // Booth accumulator: {hi (W+1), lo (W), booth bit}. The extra hi bit
  // absorbs the transient overflow of subtracting the most negative A.
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int REM_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // Sequencing state
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               op_q, op_d;
  logic               zero_div_q, zero_div_d;

  // Latched operands
  logic [WIDTH-1:0]   a_q, a_d;
  logic               b_neg_q, b_neg_d;

  // Multiply datapath
  logic [ACC_W-1:0]   acc_q, acc_d;

  // Divide datapath
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;

  // Visible results and status
  logic [WIDTH-1:0]   zhigh_q, zhigh_d;
  logic [WIDTH-1:0]   zlow_q, zlow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Combinational helpers
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     booth_hi;
  logic [WIDTH:0]     booth_hi_nxt;
  logic signed [ACC_W-1:0] acc_pre;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   rem_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [REM_W-1:0]   step_rem;
  logic               step_q;

  // Single non-restoring step, reused once per RUN cycle.
  udiv_nr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in   (rem_q),
    .divisor  (dvsr_q),
    .shift_in (quo_q[WIDTH-1]),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  // Next-state, datapath and output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    zero_div_d = zero_div_q;
    a_d        = a_q;
    b_neg_d    = b_neg_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    zhigh_d    = zhigh_q;
    zlow_d     = zlow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    // Booth: pair (b_i, b_i-1) = 01 adds A, 10 subtracts A.
    a_ext        = {a_q[WIDTH-1], a_q};
    booth_hi     = acc_q[ACC_W-1:WIDTH+1];
    booth_hi_nxt = booth_hi;
    case (acc_q[1:0])
      2'b01:   booth_hi_nxt = booth_hi + a_ext;
      2'b10:   booth_hi_nxt = booth_hi - a_ext;
      default: booth_hi_nxt = booth_hi;
    endcase
    acc_pre = {booth_hi_nxt, acc_q[WIDTH:0]};

    // Magnitudes of the raw inputs, captured at the start edge.
    mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Final restore of a negative partial remainder, then sign fixup:
    // quotient truncates toward zero, remainder follows the dividend.
    rem_fix    = rem_q[WIDTH-1:0] + (rem_q[REM_W-1] ? dvsr_q : '0);
    rem_signed = a_q[WIDTH-1] ? (~rem_fix + 1'b1) : rem_fix;
    quo_signed = (a_q[WIDTH-1] ^ b_neg_q) ? (~quo_q + 1'b1) : quo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = a;
          op_d       = op;
          b_neg_d    = b[WIDTH-1];
          dvsr_d     = mag_b;
          quo_d      = mag_a;
          rem_d      = '0;
          acc_d      = {{(WIDTH + 1){1'b0}}, b, 1'b0};
          zero_div_d = (op == OP_DIV) && (b == '0);
          dbz_d      = 1'b0;
          count_d    = '0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end

      RUN: begin
        if (op_q == OP_MUL) begin
          acc_d = acc_pre >>> 1;
        end else if (!zero_div_q) begin
          rem_d = step_rem;
          quo_d = {quo_q[WIDTH-2:0], step_q};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          state_d = FIX;
        end
      end

      FIX: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (op_q == OP_MUL) begin
          zhigh_d = acc_q[2*WIDTH:WIDTH+1];
          zlow_d  = acc_q[WIDTH:1];
        end else if (zero_div_q) begin
          zhigh_d = a_q;
          zlow_d  = '1;
          dbz_d   = 1'b1;
        end else begin
          zhigh_d = rem_signed;
          zlow_d  = quo_signed;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      op_q       <= OP_MUL;
      zero_div_q <= 1'b0;
      a_q        <= '0;
      b_neg_q    <= 1'b0;
      acc_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      zhigh_q    <= '0;
      zlow_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_q       <= op_d;
      zero_div_q <= zero_div_d;
      a_q        <= a_d;
      b_neg_q    <= b_neg_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      zhigh_q    <= zhigh_d;
      zlow_q     <= zlow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign zhigh       = zhigh_q;
  assign zlow        = zlow_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Scoreboard bench for muldiv_unit with an arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clock   = 1'b0;
  logic         clear_n = 1'b0;
  logic         start   = 1'b0;
  logic         op      = 1'b0;
  logic [W-1:0] a       = '0;
  logic [W-1:0] b       = '0;
  logic [W-1:0] zhigh;
  logic [W-1:0] zlow;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .zhigh       (zhigh),
    .zlow        (zlow),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] zh;
    logic [W-1:0] zl;
    logic         dbz;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: plain 64-bit signed arithmetic.
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, r;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    e.dbz = 1'b0;
    e.due = 0;
    if (o == 1'b0) begin
      r    = sx * sy;
      e.zh = r[63:32];
      e.zl = r[31:0];
    end else if (y == '0) begin
      e.zh  = x;
      e.zl  = '1;
      e.dbz = 1'b1;
    end else begin
      r    = sx / sy;
      e.zl = r[31:0];
      r    = sx % sy;
      e.zh = r[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (clear_n && done) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        mon_e = sb.pop_front();
        check("zhigh", zhigh, mon_e.zh);
        check("zlow", zlow, mon_e.zl);
        check("div_by_zero", div_by_zero, mon_e.dbz);
        check("latency_cycle", cyc, mon_e.due);
        check("busy_at_done", busy, 1'b0);
      end
    end
  end

  // Drive a request at the current negedge; returns at the next negedge.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e     = model(o, x, y);
    e.due = cyc + 1 + LAT;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    op    = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      fail_now("timeout_waiting_done");
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    issue(o, x, y);
    wait_idle();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h0000_0001;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (3) @(negedge clock);
    check("reset_zhigh", zhigh, 0);
    check("reset_zlow", zlow, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", div_by_zero, 0);
    clear_n = 1'b1;

    // Directed multiply cases
    @(negedge clock);
    issue(1'b0, 32'hFFFF_FFF9, 32'h0000_0003);
    check("busy_after_start", busy, 1'b1);
    wait_idle();
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    run_op(1'b0, 32'h0000_FFFF, 32'h0000_FFFF);

    // Directed divide cases
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b1, 32'h0000_002A, 32'h0000_0000);
    repeat (4) @(negedge clock);
    check("dbz_sticky", div_by_zero, 1'b1);
    check("zlow_held", zlow, 32'hFFFF_FFFF);

    // Next accepted start clears the flag on its start edge
    @(negedge clock);
    issue(1'b0, 32'h0000_0002, 32'h0000_0003);
    check("dbz_cleared_at_start", div_by_zero, 1'b0);
    wait_idle();

    // Starts while busy are ignored
    @(negedge clock);
    issue(1'b0, 32'h0000_0005, 32'hFFFF_FFF9);
    e0 = cyc;
    while (cyc < e0 + 5) @(negedge clock);
    start = 1'b1; op = 1'b1; b = '0;
    @(negedge clock);
    start = 1'b0;
    while (cyc < e0 + 20) @(negedge clock);
    start = 1'b1; op = 1'b1; a = 32'h1234_5678;
    @(negedge clock);
    start = 1'b0;

    // Back-to-back start in the done cycle
    for (int i = 0; i < 100 && !done; i++) @(negedge clock);
    if (!done) fail_now("done_not_seen");
    issue(1'b1, 32'h0000_0064, 32'h0000_0007);
    wait_idle();

    // Asynchronous abort mid-divide
    @(negedge clock);
    issue(1'b1, 32'h1234_5678, 32'h0000_0111);
    e0 = cyc;
    while (cyc < e0 + 9) @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    check("abort_zhigh", zhigh, 0);
    check("abort_zlow", zlow, 0);
    check("abort_busy", busy, 0);
    sb.delete();
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    repeat (40) @(negedge clock);
    run_op(1'b1, 32'hFFFF_FF9C, 32'h0000_0007);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      run_op(1'($urandom), pick(), pick());
    end

    wait_idle();
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle signed multiply/divide engine for the datapath ALU.
- Its 64-bit result registers drive the Zhigh and Zlow inputs of the 32:1 bus multiplexer, directly downstream.
- Operand A comes from the Y register and operand B from the bus; the control unit starts it and waits for done before asserting Zhighout/Zlowout.
- MUL uses radix-2 Booth and DIV uses non-restoring division; both take WIDTH iterations.

Parameters:
- WIDTH, 32, operand width; Z result is 2*WIDTH. Must be even and ≥4.

Ports:
- clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = MUL, 1 = DIV
- a  in  WIDTH  multiplicand / dividend (from Y), two's complement
- b  in  WIDTH  multiplier / divisor (from bus), two's complement
- zhigh  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
- zlow  out  WIDTH  MUL: product[W-1:0]; DIV: quotient
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when zhigh/zlow update
- div_by_zero  out  1  sticky until next accepted start; set with done when DIV and b==0

Behaviour:
- One clock; reset is asynchronous and active-low (clear_n). Assertion forces IDLE immediately; zhigh, zlow = 0; busy, done, div_by_zero = 0; iteration counter = 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0 latches a, b, op.
  - The same edge clears div_by_zero, sets count=0 and busy=1, and moves to RUN.
  - op and a/b are don't-care after E0.
- RUN:
  - One iteration per edge; E1..EW perform iterations 0..W-1.
  - At the edge where count==W-1, move to FIX.
- FIX, edge EW+1:
  - Sign correction.
  - zhigh/zlow written, done=1 for exactly one cycle, busy=0, return to IDLE.
  - Latency: done is visible W+1 cycles after the start edge (33 for W=32).
- MUL:
  - Booth recoding over {b, 0}, add/sub a into a 2W+1-bit accumulator with an arithmetic right shift.
  - Result is the exact signed 2W-bit product, with no overflow possible.
- DIV:
  - Operands converted to magnitude at E0.
  - Unsigned non-restoring over W iterations; remainder restore and sign fixup happen in FIX.
  - Quotient truncates toward zero; remainder takes the sign of the dividend, with |r| < |b|.
  - Special case a = -2^(W-1), b = -1: zlow = 0x80000000, zhigh = 0 (wraps, no flag).
- Divide by zero:
  - Same W+1 latency, no iterations required internally.
  - zlow = all-ones, zhigh = a, div_by_zero = 1 with done.
- Outputs hold their values between operations; the bus mux may read them any time after done.
- start while busy: ignored, with no queuing.
- start in the cycle done is high: state is already IDLE, so it is accepted.
- Reset mid-operation: abort, outputs go to 0, no done pulse.
- op/a/b changing during RUN has no effect.

Decomposition:
- Package muldiv_pkg:
  - OP_MUL = 1'b0, OP_DIV = 1'b1
  - state enum {IDLE, RUN, FIX}
  - localparam function clog2 for counter width
- Sub-module udiv_nr_step: combinational single non-restoring step (partial remainder, divisor, quotient bit in → next partial remainder, q bit out).
  - Instantiated once and iterated by the top-level FSM.
- Booth step stays inline in the top level.

Test Plan:
- MUL a=-7 (FFFFFFF9), b=3 → after 33 cycles done=1, zhigh=FFFFFFFF, zlow=FFFFFFEB, busy low same cycle.
- MUL a=80000000, b=80000000 → zhigh=40000000, zlow=00000000; also a=0000FFFF × 0000FFFF → zhigh=0, zlow=FFFE0001.
- DIV a=-7, b=2 → zlow=FFFFFFFD, zhigh=FFFFFFFF. DIV a=7, b=-2 → zlow=FFFFFFFD, zhigh=00000001. DIV a=80000000, b=FFFFFFFF → zlow=80000000, zhigh=0.
- DIV a=0000002A, b=0 → done at cycle 33, div_by_zero=1, zlow=FFFFFFFF, zhigh=0000002A.
  - Then MUL 2×3 → div_by_zero clears at its start edge, zlow=6.
- start pulsed again at cycles 5 and 20 of a MUL → ignored, single done at cycle 33; back-to-back start on the done cycle → second done exactly 33 cycles later.
- clear_n low at cycle 10 of a DIV → zhigh=zlow=0, busy=0 asynchronously (before the next edge), no done.
  - After release, a new op completes normally.
